// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates a CPU data port and a loader/debug port onto a single
//   data-memory interface, with one access in flight at any time.
//   Each access takes four states:
//     IDLE  - arbitrate and latch the winner
//     ISSUE - drive one registered strobe
//     WAIT  - capture the read data
//     RESP  - pulse the granted port's ack and arbitrate again
//   Latency is request sampled in cycle N, strobe in N+1, ack in N+3.
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined  : round robin when both ports are eligible
//                       undefined: fixed priority, CPU first
//
// Ports
//   clock, reset                    single clock, synchronous active-high reset
//   cpu_rd, cpu_wr                  CPU load/store requests (store wins if both)
//   cpu_addr, cpu_wdata             CPU address and store data
//   cpu_rdata, cpu_ack, cpu_stall   CPU response, ack pulse and stall
//   ld_req, ld_we                   loader request and direction (1 = write)
//   ld_addr, ld_wdata               loader address and write data
//   ld_rdata, ld_ack                loader response and ack pulse
//   mem_rd, mem_wr                  registered memory strobes
//   mem_addr, mem_wdata             registered memory address and write data
//   mem_rdata                       memory read data, valid the cycle after mem_rd
module dmem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_ack,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_ld_q, gnt_ld_d;      // port in flight: 1 = loader, 0 = CPU
  logic        we_q, we_d;              // direction of access in flight
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        ld_ack_q, ld_ack_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d; // CPU response register
  logic [31:0] ld_rdata_q, ld_rdata_d;   // loader response register
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_ld_q, last_ld_d;    // 1 = loader was granted last
`endif

  logic        cpu_req_s;
  logic        arb_en_s;
  logic        cpu_elig_s;
  logic        ld_elig_s;
  logic        win_cpu_s;
  logic        win_ld_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;

  // Arbitration among eligible requesters; the port being acked in RESP is excluded.
  always_comb begin
    cpu_req_s  = cpu_rd | cpu_wr;
    arb_en_s   = (state_q == ST_IDLE) || (state_q == ST_RESP);
    cpu_elig_s = cpu_req_s && !((state_q == ST_RESP) && !gnt_ld_q);
    ld_elig_s  = ld_req && !((state_q == ST_RESP) && gnt_ld_q);
    win_cpu_s  = 1'b0;
    win_ld_s   = 1'b0;
    if (arb_en_s) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (cpu_elig_s && ld_elig_s) begin
        win_cpu_s = last_ld_q;
        win_ld_s  = ~last_ld_q;
      end else begin
        win_cpu_s = cpu_elig_s;
        win_ld_s  = ld_elig_s;
      end
`else
      // Any CPU request keeps the loader out, even in the RESP cycle where
      // the CPU itself is excluded, so a busy CPU keeps its priority.
      win_cpu_s = cpu_elig_s;
      win_ld_s  = ld_elig_s && !cpu_req_s;
`endif
    end else begin
      win_cpu_s = 1'b0;
      win_ld_s  = 1'b0;
    end
    // Simultaneous cpu_rd and cpu_wr is a store.
    sel_we_s    = win_ld_s ? ld_we    : cpu_wr;
    sel_addr_s  = win_ld_s ? ld_addr  : cpu_addr;
    sel_wdata_s = win_ld_s ? ld_wdata : cpu_wdata;
  end

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    gnt_ld_d    = gnt_ld_q;
    we_d        = we_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_ld_d   = last_ld_q;
`endif
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (win_cpu_s || win_ld_s) begin
          state_d     = ST_ISSUE;
          gnt_ld_d    = win_ld_s;
          we_d        = sel_we_s;
          mem_rd_d    = ~sel_we_s;
          mem_wr_d    = sel_we_s;
          mem_addr_d  = sel_addr_s;
          mem_wdata_d = sel_wdata_s;
`ifdef ARB_ROUND_ROBIN_EN
          last_ld_d   = win_ld_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The per-port rdata registers are the response registers: loading
        // them here makes the read data appear together with the ack.
        state_d = ST_RESP;
        if (gnt_ld_q) begin
          ld_ack_d = 1'b1;
          if (!we_q) begin
            ld_rdata_d = mem_rdata;
          end else begin
            ld_rdata_d = ld_rdata_q;
          end
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) begin
            cpu_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset drops any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_ld_q    <= 1'b0;
      we_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= 32'd0;
      ld_rdata_q  <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ld_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_ld_q    <= gnt_ld_d;
      we_q        <= we_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_ld_q   <= last_ld_d;
`endif
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ld_ack    = ld_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_stall = (cpu_rd | cpu_wr) & ~cpu_ack_q;

endmodule
